// File: rtl/fp_pkg.sv
// -----------------------------------------------------------------------------
// fp_pkg
// Shared constants and helpers for the FMIN/FMAX operand-preparation path.
//   - CLASS_* : bit positions in the 10-bit RISC-V FCLASS one-hot vector
//   - FMT_S / FMT_D : format encodings (anything other than FMT_S is double)
//   - QNAN_S / QNAN_D : canonical quiet NaNs
//   - fp_fields_t : per-operand decoded fields captured in S1
//   - decode_fields() : format-aware field extraction from a raw 64-bit operand
// -----------------------------------------------------------------------------
package fp_pkg;

   localparam int FCLASS_W = 10;
   localparam int EXT_W    = 65;

   localparam int CLASS_NEG_INF  = 0;
   localparam int CLASS_NEG_NORM = 1;
   localparam int CLASS_NEG_SUB  = 2;
   localparam int CLASS_NEG_ZERO = 3;
   localparam int CLASS_POS_ZERO = 4;
   localparam int CLASS_POS_SUB  = 5;
   localparam int CLASS_POS_NORM = 6;
   localparam int CLASS_POS_INF  = 7;
   localparam int CLASS_SNAN     = 8;
   localparam int CLASS_QNAN     = 9;

   localparam logic [1:0]  FMT_S  = 2'd0;
   localparam logic [1:0]  FMT_D  = 2'd1;

   localparam logic [31:0] QNAN_S = 32'h7FC0_0000;
   localparam logic [63:0] QNAN_D = 64'h7FF8_0000_0000_0000;

   // Everything the classifier needs, reduced to single bits so S2 does no
   // wide compares: sign, exponent all-ones / all-zeros, mantissa zero, mantissa MSB.
   typedef struct packed {
      logic sign;
      logic exp_ones;
      logic exp_zero;
      logic mant_zero;
      logic mant_msb;
   } fp_fields_t;

   function automatic fp_fields_t decode_fields(input logic [63:0] d, input logic is_single);
      fp_fields_t f;
      if (is_single) begin
         f.sign      = d[31];
         f.exp_ones  = &d[30:23];
         f.exp_zero  = ~|d[30:23];
         f.mant_zero = ~|d[22:0];
         f.mant_msb  = d[22];
      end else begin
         f.sign      = d[63];
         f.exp_ones  = &d[62:52];
         f.exp_zero  = ~|d[62:52];
         f.mant_zero = ~|d[51:0];
         f.mant_msb  = d[51];
      end
      return f;
   endfunction

endpackage

// File: rtl/fp_operand_classify.sv
// -----------------------------------------------------------------------------
// fp_operand_classify
// Purely combinational: turns one operand's S1 fields into the values the
// min/max unit consumes.
// Ports:
//   is_single  in   1         operand is single precision (fmt == FMT_S)
//   fields     in   struct    decoded sign/exponent/mantissa flags
//   box_bad    in   1         single operand failed the NaN-box check
//                             (always 0 when that check is not built)
//   data       in   64        raw operand as captured in S1
//   fclass     out  10        FCLASS one-hot
//   ext        out  65        {sign, magnitude} compare word
//   data_out   out  64        operand forwarded downstream
// -----------------------------------------------------------------------------
module fp_operand_classify
   import fp_pkg::*;
(
   input  logic                is_single,
   input  fp_fields_t          fields,
   input  logic                box_bad,
   input  logic [63:0]         data,
   output logic [FCLASS_W-1:0] fclass,
   output logic [EXT_W-1:0]    ext,
   output logic [63:0]         data_out
);

   always_comb begin
      fclass = '0;
      if (box_bad) begin
         // Improperly boxed single is treated as the canonical qNaN.
         fclass[CLASS_QNAN] = 1'b1;
      end else if (fields.exp_ones) begin
         if (fields.mant_zero)
            fclass[fields.sign ? CLASS_NEG_INF : CLASS_POS_INF] = 1'b1;
         else if (fields.mant_msb)
            fclass[CLASS_QNAN] = 1'b1;
         else
            fclass[CLASS_SNAN] = 1'b1;
      end else if (fields.exp_zero) begin
         if (fields.mant_zero)
            fclass[fields.sign ? CLASS_NEG_ZERO : CLASS_POS_ZERO] = 1'b1;
         else
            fclass[fields.sign ? CLASS_NEG_SUB : CLASS_POS_SUB] = 1'b1;
      end else begin
         fclass[fields.sign ? CLASS_NEG_NORM : CLASS_POS_NORM] = 1'b1;
      end
   end

   // Magnitude is the operand with the sign stripped, zero-extended to 64
   // bits so single and double words compare with the same comparator.
   always_comb begin
      if (box_bad)
         ext = {1'b0, 33'h0, QNAN_S[30:0]};
      else if (is_single)
         ext = {fields.sign, 33'h0, data[30:0]};
      else
         ext = {fields.sign, 1'b0, data[62:0]};
   end

   always_comb begin
      if (box_bad)
         data_out = {32'h0, QNAN_S};
      else if (is_single)
         data_out = {32'h0, data[31:0]};
      else
         data_out = data;
   end

endmodule

// File: rtl/fp_minmax_prep.sv
// -----------------------------------------------------------------------------
// fp_minmax_prep
// Operand-preparation stage in front of the FMIN/FMAX unit. Two pipeline
// stages with valid/ready on both sides:
//   S1 registers both raw operands plus their decoded fields.
//   S2 registers class / compare word / forwarded data built from S1.
// Latency 2 cycles, one operation per cycle when not stalled.
//
// Build option: define FP_NANBOX_CHECK_EN to replace single-precision operands
// whose upper 32 bits are not all ones by the canonical qNaN. Without it the
// upper half of a single operand is ignored.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   flush                    synchronous kill of both stages
//   in_valid / in_ready      upstream handshake (in_ready is combinational)
//   in_data1, in_data2       raw operands (single in low 32 bits)
//   in_fmt, in_rm, in_tag    format, rounding-mode field (FMIN/FMAX), opaque tag
//   out_valid / out_ready    downstream handshake
//   out_data1/2, out_ext1/2, out_class1/2    prepared operands
//   out_fmt, out_rm, out_tag registered pass-through fields
// -----------------------------------------------------------------------------
module fp_minmax_prep
   import fp_pkg::*;
#(
   parameter int TAG_W = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                flush,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [63:0]         in_data1,
   input  logic [63:0]         in_data2,
   input  logic [1:0]          in_fmt,
   input  logic [2:0]          in_rm,
   input  logic [TAG_W-1:0]    in_tag,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [63:0]         out_data1,
   output logic [63:0]         out_data2,
   output logic [EXT_W-1:0]    out_ext1,
   output logic [EXT_W-1:0]    out_ext2,
   output logic [FCLASS_W-1:0] out_class1,
   output logic [FCLASS_W-1:0] out_class2,
   output logic [1:0]          out_fmt,
   output logic [2:0]          out_rm,
   output logic [TAG_W-1:0]    out_tag
);

   // ---------------------------------------------------------------- control
   logic s1_valid_reg;
   logic s2_valid_reg;
   logic s1_en;
   logic s2_en;
   logic s1_load;
   logic s2_load;
   logic in_is_single;

   // S2 advances when empty or being drained; S1 advances when empty or
   // when S2 will take its contents.
   assign s2_en    = !s2_valid_reg || out_ready;
   assign s1_en    = !s1_valid_reg || s2_en;
   assign in_ready = s1_en;

   // Data registers only move when a real operation moves into them, so
   // bubbles do not toggle the wide datapath. A flushed input is not loaded.
   assign s1_load = s1_en && in_valid && !flush;
   assign s2_load = s2_en && s1_valid_reg;

   assign in_is_single = (in_fmt == FMT_S);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_reg <= 1'b0;
         s2_valid_reg <= 1'b0;
      end else if (flush) begin
         s1_valid_reg <= 1'b0;
         s2_valid_reg <= 1'b0;
      end else begin
         if (s1_en)
            s1_valid_reg <= in_valid;
         if (s2_en)
            s2_valid_reg <= s1_valid_reg;
      end
   end

   assign out_valid = s2_valid_reg;

   // ------------------------------------------------- shared per-op fields
   logic             s1_is_single_reg;
   logic [1:0]       s1_fmt_reg;
   logic [2:0]       s1_rm_reg;
   logic [TAG_W-1:0] s1_tag_reg;
   logic [1:0]       out_fmt_reg;
   logic [2:0]       out_rm_reg;
   logic [TAG_W-1:0] out_tag_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_is_single_reg <= 1'b0;
         s1_fmt_reg       <= '0;
         s1_rm_reg        <= '0;
         s1_tag_reg       <= '0;
      end else if (s1_load) begin
         s1_is_single_reg <= in_is_single;
         s1_fmt_reg       <= in_fmt;
         s1_rm_reg        <= in_rm;
         s1_tag_reg       <= in_tag;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_fmt_reg <= '0;
         out_rm_reg  <= '0;
         out_tag_reg <= '0;
      end else if (s2_load) begin
         out_fmt_reg <= s1_fmt_reg;
         out_rm_reg  <= s1_rm_reg;
         out_tag_reg <= s1_tag_reg;
      end
   end

   assign out_fmt = out_fmt_reg;
   assign out_rm  = out_rm_reg;
   assign out_tag = out_tag_reg;

   // ----------------------------------------------------- operand datapath
   // Identical logic for both operands; gi selects which ports it uses.
   for (genvar gi = 0; gi < 2; gi++) begin : g_opnd
      logic [63:0]         raw_in;
      fp_fields_t          fields_next;
      logic                box_bad_next;

      logic [63:0]         s1_data_reg;
      fp_fields_t          s1_fields_reg;
      logic                s1_box_bad_reg;

      logic [FCLASS_W-1:0] class_next;
      logic [EXT_W-1:0]    ext_next;
      logic [63:0]         data_next;

      logic [FCLASS_W-1:0] out_class_reg;
      logic [EXT_W-1:0]    out_ext_reg;
      logic [63:0]         out_data_reg;

      assign raw_in      = (gi == 0) ? in_data1 : in_data2;
      assign fields_next = decode_fields(raw_in, in_is_single);

`ifdef FP_NANBOX_CHECK_EN
      // A single operand is valid only when properly NaN-boxed.
      assign box_bad_next = in_is_single && (raw_in[63:32] != 32'hFFFF_FFFF);
`else
      assign box_bad_next = 1'b0;
`endif

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            s1_data_reg    <= '0;
            s1_fields_reg  <= '0;
            s1_box_bad_reg <= 1'b0;
         end else if (s1_load) begin
            s1_data_reg    <= raw_in;
            s1_fields_reg  <= fields_next;
            s1_box_bad_reg <= box_bad_next;
         end
      end

      fp_operand_classify u_classify (
         .is_single (s1_is_single_reg),
         .fields    (s1_fields_reg),
         .box_bad   (s1_box_bad_reg),
         .data      (s1_data_reg),
         .fclass    (class_next),
         .ext       (ext_next),
         .data_out  (data_next)
      );

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            out_class_reg <= '0;
            out_ext_reg   <= '0;
            out_data_reg  <= '0;
         end else if (s2_load) begin
            out_class_reg <= class_next;
            out_ext_reg   <= ext_next;
            out_data_reg  <= data_next;
         end
      end

      if (gi == 0) begin : g_port1
         assign out_class1 = out_class_reg;
         assign out_ext1   = out_ext_reg;
         assign out_data1  = out_data_reg;
      end else begin : g_port2
         assign out_class2 = out_class_reg;
         assign out_ext2   = out_ext_reg;
         assign out_data2  = out_data_reg;
      end
   end

endmodule
